// File: rtl/fractal_sync_pkg.sv
// Shared fractal_sync types and constants.
// Includes the arbiter selector and the width of the optional stall counters.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    FA_ARB = 2'd0,
    RR_ARB = 2'd1
  } arb_e;

  localparam int unsigned FS_ARB_CNT_W = 16;

  // Pointer width for a round-robin over n inputs; never narrower than one bit.
  function automatic int unsigned fs_ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_arb_slot.sv
// One-entry valid/ready output register of the round-robin arbiter.
// Optional stall counter under FRACTAL_SYNC_ARB_STATS_EN.
module fractal_sync_arb_slot
  import fractal_sync_pkg::*;
#(
  parameter type arbiter_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     load,
  input  arbiter_t load_data,
  input  logic     ready,
  output logic     free,
  output logic     valid,
  output arbiter_t data
`ifdef FRACTAL_SYNC_ARB_STATS_EN
  ,
  input  logic                    clear_stats,
  output logic [FS_ARB_CNT_W-1:0] stall_cnt
`endif
);

  logic     valid_q;
  arbiter_t data_q;

  assign free  = !valid_q || ready;
  assign valid = valid_q;
  assign data  = valid_q ? data_q : '0;

  // A load always wins over a drain, so a consumed slot can refill in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef FRACTAL_SYNC_ARB_STATS_EN
  logic [FS_ARB_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_stats) begin
      cnt_q <= '0;
    end else if (valid_q && !ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: rtl/fractal_sync_arbiter_rr.sv
// N-input, M-output round-robin arbiter with registered, backpressured outputs.
// Define FRACTAL_SYNC_ARB_STATS_EN to add per-output stall counters.
module fractal_sync_arbiter_rr
  import fractal_sync_pkg::*;
#(
  parameter int unsigned IN_PORTS  = 4,
  parameter int unsigned OUT_PORTS = 2,
  parameter type         arbiter_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  output logic     pop_o     [IN_PORTS],
  input  logic     empty_i   [IN_PORTS],
  input  arbiter_t element_i [IN_PORTS],
  output logic     valid_o   [OUT_PORTS],
  input  logic     ready_i   [OUT_PORTS],
  output arbiter_t element_o [OUT_PORTS]
`ifdef FRACTAL_SYNC_ARB_STATS_EN
  ,
  input  logic                    clear_stats_i,
  output logic [FS_ARB_CNT_W-1:0] stall_cnt_o [OUT_PORTS]
`endif
);

  localparam int unsigned PTR_W = fs_ptr_w(IN_PORTS);

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_next;
  logic [PTR_W-1:0]    last_idx;
  logic [IN_PORTS-1:0] taken;
  logic                any_grant;
  logic                found;
  int                  idx;
  logic                slot_free [OUT_PORTS];
  logic                slot_load [OUT_PORTS];
  arbiter_t            load_data [OUT_PORTS];

  // Slots are served in ascending order, each taking the next pending input
  // after rr_ptr, so the final grant is also the last one in circular order.
  always_comb begin
    taken     = '0;
    any_grant = 1'b0;
    last_idx  = rr_ptr;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < int'(OUT_PORTS); i++) begin
      slot_load[i] = 1'b0;
      load_data[i] = '0;
    end
    for (int i = 0; i < int'(OUT_PORTS); i++) begin
      found = 1'b0;
      if (slot_free[i]) begin
        for (int k = 0; k < int'(IN_PORTS); k++) begin
          idx = (int'(rr_ptr) + k) % int'(IN_PORTS);
          for (int j = 0; j < int'(IN_PORTS); j++) begin
            if ((j == idx) && !found && !empty_i[j] && !taken[j]) begin
              found        = 1'b1;
              taken[j]     = 1'b1;
              slot_load[i] = 1'b1;
              load_data[i] = element_i[j];
              last_idx     = PTR_W'(j);
              any_grant    = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (any_grant) begin
      rr_next = (last_idx == PTR_W'(IN_PORTS - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  if (IN_PORTS == 1) begin : g_single_ptr
    assign rr_ptr = '0;
  end else begin : g_rr_ptr
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= rr_next;
      end
    end
  end

  // Gating with rst_ni keeps the FIFOs untouched while the arbiter is held in reset.
  for (genvar gi = 0; gi < IN_PORTS; gi++) begin : g_pop
    assign pop_o[gi] = taken[gi] & rst_ni;
  end

  for (genvar gi = 0; gi < OUT_PORTS; gi++) begin : g_slot
    fractal_sync_arb_slot #(
      .arbiter_t (arbiter_t)
    ) i_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load        (slot_load[gi]),
      .load_data   (load_data[gi]),
      .ready       (ready_i[gi]),
      .free        (slot_free[gi]),
      .valid       (valid_o[gi]),
      .data        (element_o[gi])
`ifdef FRACTAL_SYNC_ARB_STATS_EN
      ,
      .clear_stats (clear_stats_i),
      .stall_cnt   (stall_cnt_o[gi])
`endif
    );
  end

endmodule

// File: tb/tb_fractal_sync_arbiter_rr.sv
// Directed bench for fractal_sync_arbiter_rr: a 4x2 vector table, async reset,
// and a 3x1 instance for non-power-of-2 wrap. Stall counters checked with FRACTAL_SYNC_ARB_STATS_EN.
module tb_fractal_sync_arbiter_rr;

  logic clk;
  logic rst_n;

  logic       pop      [4];
  logic       empty    [4];
  logic [7:0] elem_in  [4];
  logic       valid    [2];
  logic       ready    [2];
  logic [7:0] elem_out [2];

  logic       pop3      [3];
  logic       empty3    [3];
  logic [7:0] elem_in3  [3];
  logic       valid3    [1];
  logic       ready3    [1];
  logic [7:0] elem_out3 [1];

`ifdef FRACTAL_SYNC_ARB_STATS_EN
  logic        clear;
  logic [15:0] stall  [2];
  logic        clear3;
  logic [15:0] stall3 [1];
`endif

  fractal_sync_arbiter_rr #(
    .IN_PORTS  (4),
    .OUT_PORTS (2),
    .arbiter_t (logic [7:0])
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pop_o         (pop),
    .empty_i       (empty),
    .element_i     (elem_in),
    .valid_o       (valid),
    .ready_i       (ready),
    .element_o     (elem_out)
`ifdef FRACTAL_SYNC_ARB_STATS_EN
    ,
    .clear_stats_i (clear),
    .stall_cnt_o   (stall)
`endif
  );

  fractal_sync_arbiter_rr #(
    .IN_PORTS  (3),
    .OUT_PORTS (1),
    .arbiter_t (logic [7:0])
  ) dut3 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pop_o         (pop3),
    .empty_i       (empty3),
    .element_i     (elem_in3),
    .valid_o       (valid3),
    .ready_i       (ready3),
    .element_o     (elem_out3)
`ifdef FRACTAL_SYNC_ARB_STATS_EN
    ,
    .clear_stats_i (clear3),
    .stall_cnt_o   (stall3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] pop_vec;
  logic [2:0] pop3_vec;
  logic [1:0] valid_vec;
  always_comb begin
    for (int j = 0; j < 4; j++) pop_vec[j] = pop[j];
    for (int j = 0; j < 3; j++) pop3_vec[j] = pop3[j];
    for (int j = 0; j < 2; j++) valid_vec[j] = valid[j];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] empty;
    logic [1:0] ready;
    logic [3:0] exp_pop;
    logic [1:0] exp_valid;
    logic [7:0] exp_e0;
    logic [7:0] exp_e1;
  } vec_t;

  typedef struct {
    logic [2:0] empty;
    logic [2:0] exp_pop;
    logic [7:0] exp_e;
  } vec3_t;

  vec_t  vecs  [14];
  vec3_t vecs3 [6];

  task automatic drive_all(input logic [3:0] emp, input logic [1:0] rdy, input logic [7:0] base);
    for (int j = 0; j < 4; j++) begin
      empty[j]   = emp[j];
      elem_in[j] = base + 8'(j);
    end
    for (int j = 0; j < 2; j++) ready[j] = rdy[j];
  endtask

  initial begin
    // Element value of input j in row r is r*16+j.
    vecs[0]  = '{4'b0000, 2'b11, 4'b0011, 2'b11, 8'h00, 8'h01};
    vecs[1]  = '{4'b0000, 2'b11, 4'b1100, 2'b11, 8'h12, 8'h13};
    vecs[2]  = '{4'b0000, 2'b11, 4'b0011, 2'b11, 8'h20, 8'h21};
    vecs[3]  = '{4'b1011, 2'b11, 4'b0100, 2'b01, 8'h32, 8'h00};
    vecs[4]  = '{4'b1111, 2'b11, 4'b0000, 2'b00, 8'h00, 8'h00};
    vecs[5]  = '{4'b1011, 2'b11, 4'b0100, 2'b01, 8'h52, 8'h00};
    vecs[6]  = '{4'b0000, 2'b10, 4'b1000, 2'b11, 8'h52, 8'h63};
    vecs[7]  = '{4'b0000, 2'b10, 4'b0001, 2'b11, 8'h52, 8'h70};
    vecs[8]  = '{4'b0000, 2'b10, 4'b0010, 2'b11, 8'h52, 8'h81};
    vecs[9]  = '{4'b0000, 2'b10, 4'b0100, 2'b11, 8'h52, 8'h92};
    vecs[10] = '{4'b0000, 2'b10, 4'b1000, 2'b11, 8'h52, 8'hA3};
    vecs[11] = '{4'b0000, 2'b11, 4'b0011, 2'b11, 8'hB0, 8'hB1};
    vecs[12] = '{4'b0101, 2'b11, 4'b1010, 2'b11, 8'hC3, 8'hC1};
    vecs[13] = '{4'b0000, 2'b01, 4'b0100, 2'b11, 8'hD2, 8'hC1};

    // 3x1 instance: element of input j in step s is 0x40+s*16+j.
    vecs3[0] = '{3'b000, 3'b001, 8'h40};
    vecs3[1] = '{3'b000, 3'b010, 8'h51};
    vecs3[2] = '{3'b000, 3'b100, 8'h62};
    vecs3[3] = '{3'b000, 3'b001, 8'h70};
    vecs3[4] = '{3'b010, 3'b100, 8'h82};
    vecs3[5] = '{3'b010, 3'b001, 8'h90};

    rst_n = 1'b0;
    drive_all(4'b0000, 2'b11, 8'h00);
    for (int j = 0; j < 3; j++) begin
      empty3[j]   = 1'b1;
      elem_in3[j] = 8'h00;
    end
    ready3[0] = 1'b1;
`ifdef FRACTAL_SYNC_ARB_STATS_EN
    clear  = 1'b0;
    clear3 = 1'b0;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_pop", 32'(pop_vec), 32'h0);
    check("reset_valid", 32'(valid_vec), 32'h0);
    check("reset_e0", 32'(elem_out[0]), 32'h0);
    check("reset_e1", 32'(elem_out[1]), 32'h0);
`ifdef FRACTAL_SYNC_ARB_STATS_EN
    check("reset_stall0", 32'(stall[0]), 32'h0);
`endif
    drive_all(4'b1111, 2'b11, 8'h00);
    rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      drive_all(vecs[r].empty, vecs[r].ready, 8'(r * 16));
      #1;
      check($sformatf("row%0d_pop", r), 32'(pop_vec), 32'(vecs[r].exp_pop));
      @(posedge clk);
      #1;
      $display("row %0d: pop=%b valid=%b e0=%h e1=%h", r, vecs[r].exp_pop, valid_vec,
               elem_out[0], elem_out[1]);
      check($sformatf("row%0d_valid", r), 32'(valid_vec), 32'(vecs[r].exp_valid));
      check($sformatf("row%0d_e0", r), 32'(elem_out[0]), 32'(vecs[r].exp_e0));
      check($sformatf("row%0d_e1", r), 32'(elem_out[1]), 32'(vecs[r].exp_e1));
`ifdef FRACTAL_SYNC_ARB_STATS_EN
      if (r == 10) check("stall0_after_5", 32'(stall[0]), 32'd5);
      if (r == 13) check("stall1_after_1", 32'(stall[1]), 32'd1);
`endif
    end

`ifdef FRACTAL_SYNC_ARB_STATS_EN
    // Both slots stalled while clearing: clear must beat the increment.
    @(negedge clk);
    drive_all(4'b1111, 2'b00, 8'h00);
    clear = 1'b1;
    @(posedge clk);
    #1;
    $display("clear: stall0=%0d stall1=%0d", stall[0], stall[1]);
    check("clear_stall0", 32'(stall[0]), 32'h0);
    check("clear_stall1", 32'(stall[1]), 32'h0);
    check("clear_valid_held", 32'(valid_vec), 32'h3);
    clear = 1'b0;
`endif

    // Asynchronous reset mid-cycle with both slots full and inputs pending.
    @(negedge clk);
    drive_all(4'b0000, 2'b11, 8'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: pop=%b valid=%b e0=%h e1=%h", pop_vec, valid_vec, elem_out[0], elem_out[1]);
    check("areset_pop", 32'(pop_vec), 32'h0);
    check("areset_valid", 32'(valid_vec), 32'h0);
    check("areset_e0", 32'(elem_out[0]), 32'h0);
    check("areset_e1", 32'(elem_out[1]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("restart_pop", 32'(pop_vec), 32'h3);
    @(posedge clk);
    #1;
    $display("restart: valid=%b e0=%h e1=%h", valid_vec, elem_out[0], elem_out[1]);
    check("restart_e0", 32'(elem_out[0]), 32'hE0);
    check("restart_e1", 32'(elem_out[1]), 32'hE1);
    @(negedge clk);
    drive_all(4'b1111, 2'b11, 8'h00);

    // 3-input, 1-output instance: wrap at 3 and skip of an empty input.
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        empty3[j]   = vecs3[s].empty[j];
        elem_in3[j] = 8'(8'h40 + s * 16 + j);
      end
      #1;
      check($sformatf("n3_step%0d_pop", s), 32'(pop3_vec), 32'(vecs3[s].exp_pop));
      @(posedge clk);
      #1;
      $display("n3 step %0d: pop=%b valid=%b e=%h", s, vecs3[s].exp_pop, valid3[0], elem_out3[0]);
      check($sformatf("n3_step%0d_valid", s), 32'(valid3[0]), 32'h1);
      check($sformatf("n3_step%0d_e", s), 32'(elem_out3[0]), 32'(vecs3[s].exp_e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
